// File: rtl/daq_sequencer.sv
// daq_sequencer: periodic ADC/DAC strobe scheduler with FIFO hold-off,
// slot-loss statistics and handshake timeout.
module daq_sequencer #(
  parameter int unsigned PER_W = 16,
  parameter int unsigned CNT_W = 16,
  parameter int unsigned TMO   = 1023
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             stop,
  input  logic [PER_W-1:0] cfg_period,
  input  logic [CNT_W-1:0] cfg_count,
  input  logic             adc_done,
  input  logic             dac_done,
  input  logic             fifo_full,
  output logic             adc_sample,
  output logic             dac_start,
  output logic             busy,
  output logic             run_done,
  output logic             overrun,
  output logic             err_tmo,
  output logic [CNT_W-1:0] sample_cnt,
  output logic [CNT_W-1:0] miss_cnt,
  output logic [CNT_W-1:0] drop_cnt
);

  localparam int unsigned      WAIT_W    = $clog2(TMO + 1);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TMO - 1);
  localparam logic [CNT_W-1:0]  CNT_MAX   = '1;

  typedef enum logic [1:0] {S_IDLE, S_CONV, S_DAC, S_WAIT} state_e;

  state_e             state_q, state_d;
  logic [PER_W-1:0]   per_q, per_d, pcnt_q, pcnt_d;
  logic [CNT_W-1:0]   lim_q, lim_d;
  logic [WAIT_W-1:0]  wait_q, wait_d;
  logic               pend_q, pend_d, stop_q, stop_d;
  logic               overrun_q, overrun_d, err_tmo_q, err_tmo_d;
  logic [CNT_W-1:0]   sample_cnt_q, sample_cnt_d, miss_cnt_q, miss_cnt_d;
  logic [CNT_W-1:0]   drop_cnt_q, drop_cnt_d;
  logic               adc_sample_q, adc_sample_d, dac_start_q, dac_start_d;
  logic               busy_q, busy_d, run_done_q, run_done_d;

  logic               tick, end_run, tmo_hit, slot_drop, slot_take;
  logic [PER_W-1:0]   per_eff;

  // Effective period: 0 and 1 behave as 2; slot tick when the counter hits 0.
  assign per_eff = (cfg_period < PER_W'(2)) ? PER_W'(2) : cfg_period;
  assign tick    = (state_q != S_IDLE) && (pcnt_q == '0);

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic and transition events.
  always_comb begin
    state_d   = state_q;
    end_run   = 1'b0;
    tmo_hit   = 1'b0;
    slot_drop = 1'b0;
    slot_take = 1'b0;
    case (state_q)
      S_IDLE: if (start) state_d = S_CONV;
      S_CONV: begin
        if (adc_done) begin
          state_d = S_DAC;
        end else if (wait_q == WAIT_LAST) begin
          state_d = S_IDLE;
          tmo_hit = 1'b1;
        end
      end
      S_DAC: begin
        if (dac_done) begin
          if (((lim_q != '0) && (sample_cnt_q == lim_q)) || stop_q) begin
            state_d = S_IDLE;
            end_run = 1'b1;
          end else begin
            state_d = S_WAIT;
          end
        end else if (wait_q == WAIT_LAST) begin
          state_d = S_IDLE;
          tmo_hit = 1'b1;
        end
      end
      S_WAIT: begin
        if (stop_q) begin
          state_d = S_IDLE;
          end_run = 1'b1;
        end else if (tick || pend_q) begin
          if (fifo_full) begin
            slot_drop = 1'b1;
          end else begin
            slot_take = 1'b1;
            state_d   = S_CONV;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Datapath and registered-output next values.
  always_comb begin
    per_d        = per_q;
    lim_d        = lim_q;
    pcnt_d       = pcnt_q;
    pend_d       = pend_q;
    stop_d       = stop_q;
    overrun_d    = overrun_q;
    err_tmo_d    = err_tmo_q;
    sample_cnt_d = sample_cnt_q;
    miss_cnt_d   = miss_cnt_q;
    drop_cnt_d   = drop_cnt_q;
    if (state_q == S_IDLE) begin
      if (start) begin
        per_d        = per_eff;
        lim_d        = cfg_count;
        pcnt_d       = per_eff - PER_W'(1);
        overrun_d    = 1'b0;
        err_tmo_d    = 1'b0;
        sample_cnt_d = '0;
        miss_cnt_d   = '0;
        drop_cnt_d   = '0;
      end
    end else begin
      pcnt_d = tick ? (per_q - PER_W'(1)) : (pcnt_q - PER_W'(1));
      stop_d = stop_q | stop;
      if (tick && pend_q) begin
        overrun_d = 1'b1;
        if (miss_cnt_q != CNT_MAX) miss_cnt_d = miss_cnt_q + CNT_W'(1);
      end
      if (tick && ((state_q == S_CONV) || (state_q == S_DAC))) pend_d = 1'b1;
      if (slot_drop || slot_take) pend_d = 1'b0;
      if (slot_drop && (drop_cnt_q != CNT_MAX)) drop_cnt_d = drop_cnt_q + CNT_W'(1);
      if ((state_q == S_CONV) && adc_done) sample_cnt_d = sample_cnt_q + CNT_W'(1);
      if (tmo_hit) err_tmo_d = 1'b1;
    end
    if (state_d == S_IDLE) begin
      stop_d = 1'b0;
      pend_d = 1'b0;
    end
    if ((state_d == state_q) && ((state_q == S_CONV) || (state_q == S_DAC)))
      wait_d = wait_q + WAIT_W'(1);
    else
      wait_d = '0;
    adc_sample_d = (state_d == S_CONV) && (state_q != S_CONV);
    dac_start_d  = (state_d == S_DAC) && (state_q != S_DAC);
    busy_d       = (state_d != S_IDLE);
    run_done_d   = end_run;
  end

  // Datapath and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      per_q        <= '0;
      lim_q        <= '0;
      pcnt_q       <= '0;
      wait_q       <= '0;
      pend_q       <= 1'b0;
      stop_q       <= 1'b0;
      overrun_q    <= 1'b0;
      err_tmo_q    <= 1'b0;
      sample_cnt_q <= '0;
      miss_cnt_q   <= '0;
      drop_cnt_q   <= '0;
      adc_sample_q <= 1'b0;
      dac_start_q  <= 1'b0;
      busy_q       <= 1'b0;
      run_done_q   <= 1'b0;
    end else begin
      per_q        <= per_d;
      lim_q        <= lim_d;
      pcnt_q       <= pcnt_d;
      wait_q       <= wait_d;
      pend_q       <= pend_d;
      stop_q       <= stop_d;
      overrun_q    <= overrun_d;
      err_tmo_q    <= err_tmo_d;
      sample_cnt_q <= sample_cnt_d;
      miss_cnt_q   <= miss_cnt_d;
      drop_cnt_q   <= drop_cnt_d;
      adc_sample_q <= adc_sample_d;
      dac_start_q  <= dac_start_d;
      busy_q       <= busy_d;
      run_done_q   <= run_done_d;
    end
  end

  assign adc_sample = adc_sample_q;
  assign dac_start  = dac_start_q;
  assign busy       = busy_q;
  assign run_done   = run_done_q;
  assign overrun    = overrun_q;
  assign err_tmo    = err_tmo_q;
  assign sample_cnt = sample_cnt_q;
  assign miss_cnt   = miss_cnt_q;
  assign drop_cnt   = drop_cnt_q;

endmodule

// File: tb/tb_daq_sequencer.sv
// Testbench for daq_sequencer: table of nominal runs plus hand-written
// corner-case sequences, strobe/done timing checked through a scoreboard.
module tb_daq_sequencer;

  logic        clk = 1'b0;
  logic        rst, start, stop, fifo_full;
  logic [15:0] cfg_period, cfg_count;
  logic        adc_done, dac_done;
  logic        adc_sample, dac_start, busy, run_done, overrun, err_tmo;
  logic [15:0] sample_cnt, miss_cnt, drop_cnt;

  always #5 clk = ~clk;

  daq_sequencer #(.PER_W(16), .CNT_W(16), .TMO(1023)) dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop),
    .cfg_period(cfg_period), .cfg_count(cfg_count),
    .adc_done(adc_done), .dac_done(dac_done), .fifo_full(fifo_full),
    .adc_sample(adc_sample), .dac_start(dac_start), .busy(busy),
    .run_done(run_done), .overrun(overrun), .err_tmo(err_tmo),
    .sample_cnt(sample_cnt), .miss_cnt(miss_cnt), .drop_cnt(drop_cnt)
  );

  typedef struct {
    int per; int cnt; int la; int ld;
    int exp_samples; int exp_miss; int exp_drop;
  } vec_t;

  int vec_cnt = 0;
  int err_cnt = 0;
  int cyc = 0;
  int cyc0 = 0;
  int la = 2, ld = 2;
  bit adc_en = 1'b1;
  int exp_strobe_q[$];
  int exp_dac_q[$];
  int exp_done_q[$];

  task automatic chk(input string name, input int act, input int exp);
    vec_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // ADC responder: adc_done pulse la cycles after the strobe.
  initial begin
    adc_done = 1'b0;
    forever begin
      @(negedge clk);
      if (adc_sample && adc_en) begin
        repeat (la) @(negedge clk);
        adc_done = 1'b1;
        @(negedge clk);
        adc_done = 1'b0;
      end
    end
  end

  // DAC responder: dac_done pulse ld cycles after the strobe.
  initial begin
    dac_done = 1'b0;
    forever begin
      @(negedge clk);
      if (dac_start) begin
        repeat (ld) @(negedge clk);
        dac_done = 1'b1;
        @(negedge clk);
        dac_done = 1'b0;
      end
    end
  end

  // Scoreboard: pop the expected cycle for every strobe/done the DUT emits.
  initial forever begin
    int rel;
    @(negedge clk);
    rel = cyc - cyc0;
    if (adc_sample) begin
      if (exp_strobe_q.size() == 0) chk("adc_sample_unexpected", rel, -1);
      else chk("adc_sample_cycle", rel, exp_strobe_q.pop_front());
    end
    if (dac_start) begin
      if (exp_dac_q.size() == 0) chk("dac_start_unexpected", rel, -1);
      else chk("dac_start_cycle", rel, exp_dac_q.pop_front());
    end
    if (run_done) begin
      if (exp_done_q.size() == 0) chk("run_done_unexpected", rel, -1);
      else chk("run_done_cycle", rel, exp_done_q.pop_front());
    end
  end

  task automatic start_run(input int per, input int cnt);
    @(negedge clk);
    cfg_period = 16'(per);
    cfg_count  = 16'(cnt);
    start      = 1'b1;
    cyc0       = cyc;
    @(negedge clk);
    start      = 1'b0;
  endtask

  task automatic goto(input int r);
    while ((cyc - cyc0) < r) @(negedge clk);
  endtask

  task automatic chk_queues(input string tag);
    chk({tag, "_strobes_left"}, exp_strobe_q.size(), 0);
    chk({tag, "_dac_left"}, exp_dac_q.size(), 0);
    chk({tag, "_done_left"}, exp_done_q.size(), 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[5];
    int   last;
    vecs[0] = '{per: 10,  cnt: 3, la: 2, ld: 2, exp_samples: 3, exp_miss: 0, exp_drop: 0};
    vecs[1] = '{per: 6,   cnt: 4, la: 1, ld: 1, exp_samples: 4, exp_miss: 0, exp_drop: 0};
    vecs[2] = '{per: 20,  cnt: 2, la: 5, ld: 7, exp_samples: 2, exp_miss: 0, exp_drop: 0};
    vecs[3] = '{per: 7,   cnt: 5, la: 1, ld: 2, exp_samples: 5, exp_miss: 0, exp_drop: 0};
    vecs[4] = '{per: 300, cnt: 2, la: 3, ld: 4, exp_samples: 2, exp_miss: 0, exp_drop: 0};

    rst = 1'b1; start = 1'b0; stop = 1'b0; fifo_full = 1'b0;
    cfg_period = '0; cfg_count = '0;
    repeat (3) @(negedge clk);
    chk("rst_busy", int'(busy), 0);
    chk("rst_adc_sample", int'(adc_sample), 0);
    chk("rst_run_done", int'(run_done), 0);
    chk("rst_sample_cnt", int'(sample_cnt), 0);
    rst = 1'b0;
    @(negedge clk);

    // Nominal runs: strobes every P cycles, done right after the last DAC frame.
    foreach (vecs[i]) begin
      la = vecs[i].la; ld = vecs[i].ld;
      last = 0;
      for (int k = 0; k < vecs[i].cnt; k++) begin
        last = 1 + k * vecs[i].per;
        exp_strobe_q.push_back(last);
        exp_dac_q.push_back(last + la + 1);
      end
      exp_done_q.push_back(last + la + ld + 2);
      start_run(vecs[i].per, vecs[i].cnt);
      chk("busy_at_start", int'(busy), 1);
      goto(last + la + ld + 6);
      chk_queues("tbl");
      chk("tbl_sample_cnt", int'(sample_cnt), vecs[i].exp_samples);
      chk("tbl_miss_cnt", int'(miss_cnt), vecs[i].exp_miss);
      chk("tbl_drop_cnt", int'(drop_cnt), vecs[i].exp_drop);
      chk("tbl_overrun", int'(overrun), 0);
      chk("tbl_busy_end", int'(busy), 0);
    end

    // Period 0 and 1 behave as 2: every slot overlaps the handshake.
    for (int p = 0; p < 2; p++) begin
      la = 1; ld = 1;
      exp_strobe_q = '{1, 6}; exp_dac_q = '{3, 8}; exp_done_q = '{10};
      start_run(p, 2);
      goto(14);
      chk_queues("p_min");
      chk("p_min_miss", int'(miss_cnt), 2);
      chk("p_min_overrun", int'(overrun), 1);
      chk("p_min_samples", int'(sample_cnt), 2);
    end

    // P=4 with a slow DAC: missed slots counted, strobes wait for the handshake.
    la = 1; ld = 9;
    exp_strobe_q = '{1, 14}; exp_dac_q = '{3, 16}; exp_done_q = '{26};
    start_run(4, 2);
    goto(30);
    chk_queues("ovr");
    chk("ovr_miss", int'(miss_cnt), 4);
    chk("ovr_overrun", int'(overrun), 1);
    chk("ovr_samples", int'(sample_cnt), 2);

    // Continuous mode, FIFO full over two slots, then stop mid-CONV.
    la = 2; ld = 2;
    exp_strobe_q = '{1, 11, 21, 51}; exp_dac_q = '{4, 14, 24, 54}; exp_done_q = '{57};
    start_run(10, 0);
    chk("cont_overrun_cleared", int'(overrun), 0);
    goto(26); fifo_full = 1'b1;
    goto(45); fifo_full = 1'b0;
    chk("fifo_drop_mid", int'(drop_cnt), 2);
    chk("fifo_busy_mid", int'(busy), 1);
    goto(52); stop = 1'b1;
    goto(53); stop = 1'b0;
    goto(90);
    chk_queues("fifo");
    chk("fifo_drop", int'(drop_cnt), 2);
    chk("fifo_samples", int'(sample_cnt), 4);
    chk("fifo_miss", int'(miss_cnt), 0);
    chk("stop_busy", int'(busy), 0);

    // ADC never answers: timeout after 1023 cycles in CONV, no run_done.
    adc_en = 1'b0;
    exp_strobe_q = '{1};
    start_run(10, 0);
    goto(1023);
    chk("tmo_before_err", int'(err_tmo), 0);
    chk("tmo_before_busy", int'(busy), 1);
    goto(1024);
    chk("tmo_err", int'(err_tmo), 1);
    chk("tmo_busy", int'(busy), 0);
    goto(1030);
    chk_queues("tmo");
    adc_en = 1'b1;
    exp_strobe_q = '{1}; exp_dac_q = '{4}; exp_done_q = '{7};
    start_run(10, 1);
    chk("tmo_cleared", int'(err_tmo), 0);
    chk("tmo_ovr_cleared", int'(overrun), 0);
    goto(12);
    chk_queues("tmo2");
    chk("tmo2_samples", int'(sample_cnt), 1);

    // Reset during DAC, then a clean run with mid-run start and stop+count.
    exp_strobe_q = '{1}; exp_dac_q = '{4};
    start_run(10, 5);
    goto(5); rst = 1'b1;
    goto(6);
    chk("rst2_busy", int'(busy), 0);
    chk("rst2_dac_start", int'(dac_start), 0);
    chk("rst2_adc_sample", int'(adc_sample), 0);
    chk("rst2_run_done", int'(run_done), 0);
    chk("rst2_overrun", int'(overrun), 0);
    chk("rst2_err_tmo", int'(err_tmo), 0);
    chk("rst2_sample_cnt", int'(sample_cnt), 0);
    chk("rst2_miss_cnt", int'(miss_cnt), 0);
    chk("rst2_drop_cnt", int'(drop_cnt), 0);
    chk_queues("rst2");
    rst = 1'b0;
    exp_strobe_q = '{1, 11}; exp_dac_q = '{4, 14}; exp_done_q = '{17};
    start_run(10, 2);
    goto(4); start = 1'b1; cfg_period = 16'd3; cfg_count = 16'd9;
    goto(5); start = 1'b0;
    goto(15); stop = 1'b1;
    goto(16); stop = 1'b0;
    goto(25);
    chk_queues("restart");
    chk("restart_samples", int'(sample_cnt), 2);
    chk("restart_busy", int'(busy), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule

// File: doc/daq_sequencer.md
# daq_sequencer

Sample-rate scheduler for the DAQ datapath: the SPI ADC, the sample FIFO and the SPI DAC. It issues periodic ADC conversion strobes and DAC update strobes from a programmable period counter and stops after a programmed sample count or on request. It holds off conversions while the FIFO is full and reports missed and dropped sample slots plus handshake timeouts. It replaces the raw external `start_sample` trigger that currently fans out to the ADC, DAC, FIFO enable and UART.

## Interface
- `PER_W`, 16: width of the sample period in `clk` cycles.
- `CNT_W`, 16: width of the sample-count and statistics counters.
- `TMO`, 1023: maximum cycles to wait for `adc_done` or `dac_done` before an error.
- `clk` in 1: system clock; all logic on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `start` in 1: run request, sampled in IDLE only.
- `stop` in 1: graceful stop request; ignored in IDLE.
- `cfg_period` in PER_W: cycles between conversion slots, latched on start. Values 0 and 1 are treated as 2.
- `cfg_count` in CNT_W: samples per run, latched on start. 0 means continuous.
- `adc_done` in 1: one-cycle pulse; ADC word has been written toward the FIFO.
- `dac_done` in 1: one-cycle pulse; DAC frame complete.
- `fifo_full` in 1: FIFO full flag.
- `adc_sample` out 1: one-cycle conversion strobe to the SPI ADC.
- `dac_start` out 1: one-cycle update strobe to the SPI DAC.
- `busy` out 1: high in every state except IDLE.
- `run_done` out 1: one-cycle pulse when a run ends normally (count reached or stop).
- `overrun` out 1: sticky; a slot was missed. Cleared on an accepted start or on `rst`.
- `err_tmo` out 1: sticky handshake timeout. Cleared on an accepted start or on `rst`.
- `sample_cnt` out CNT_W: samples completed in this run.
- `miss_cnt` out CNT_W: slots lost because of overrun. Saturates at the maximum value.
- `drop_cnt` out CNT_W: slots skipped because of `fifo_full`. Saturates at the maximum value.

## Operation
- States:
  - IDLE: waits for a run request.
  - CONV: waits for `adc_done`.
  - DAC: waits for `dac_done`.
  - WAIT: waits for the next slot.
- IDLE + `start`:
  - Latch config; effective period P = max(cfg_period, 2).
  - Clear the sticky flags and all counters.
  - Load the period counter with P-1.
  - Go to CONV.
- Period counter:
  - Runs in CONV, DAC and WAIT.
  - Decrements each cycle.
  - At 0 it raises an internal tick for one cycle and reloads P-1.
  - Result: one tick every P cycles, first tick P cycles after CONV entry.
- Pending slot flag:
  - A tick in CONV or DAC sets `pend`.
  - A tick while `pend` is already set sets `overrun` and increments `miss_cnt`.
- CONV:
  - `adc_sample` pulses in the first cycle of the state.
  - On `adc_done`: increment `sample_cnt`, go to DAC.
- DAC:
  - `dac_start` pulses in the first cycle of the state.
  - On `dac_done`:
    - If `cfg_count`≠0 and `sample_cnt`==`cfg_count`: pulse `run_done`, go to IDLE.
    - Else if a stop request is latched: pulse `run_done`, go to IDLE.
    - Else go to WAIT.
- WAIT, in priority order:
  1. Stop latched: pulse `run_done`, go to IDLE.
  2. Tick or `pend` with `fifo_full`=1: increment `drop_cnt`, clear `pend`, stay in WAIT.
  3. Tick or `pend` with `fifo_full`=0: clear `pend`, go to CONV.
- `stop` sets a stop-request latch. It never aborts CONV or DAC; the latch is cleared on entry to IDLE.
- Timeout:
  - A per-state wait counter is cleared on entry to CONV or DAC.
  - If it reaches TMO without the expected done: set `err_tmo`, go to IDLE, no `run_done`.
- `start` asserted while not in IDLE is ignored. Config changes mid-run have no effect.

## Timing
- Reset (synchronous, `rst`=1 at an edge):
  - State goes to IDLE.
  - All outputs and counters are 0, `pend` is 0, stop latch is 0.
  - Reset wins over every other input in the same cycle.
- Latency:
  - `start` sampled at edge N: `busy` and `adc_sample` are high in cycle N+1.
  - `adc_done` at edge M: `dac_start` is high in cycle M+1.
- Conversion strobes are exactly P cycles apart whenever the ADC and DAC handshakes finish within P-2 cycles.
- Simultaneous events:
  - Tick on the same edge as `dac_done`: sets `pend`; WAIT then launches CONV on the next edge.
  - Stop latch and count reached on the same `dac_done`: one `run_done` only.
- `sample_cnt` holds its final value in IDLE until the next accepted start.

## Test plan
- Start with P=10, count=3, ADC/DAC done after 2 cycles:
  - 3 `adc_sample` pulses at cycles 1, 11, 21.
  - `run_done` once; `sample_cnt`=3, `miss_cnt`=0.
- P=4 with `dac_done` delayed 9 cycles:
  - `overrun`=1 and `miss_cnt` increments.
  - Strobes never closer than the handshake completes.
- `fifo_full` held high over 2 slots in continuous mode: `drop_cnt`=2, no `adc_sample` during the hold, sampling resumes on the first slot after release.
- Stop asserted mid-CONV: current DAC update completes, then `run_done`, `busy`=0, no further strobes.
- `adc_done` never arrives, TMO=1023: `err_tmo`=1 after 1023 cycles in CONV, IDLE, no `run_done`; the next start clears `err_tmo`.
- `rst` pulsed during DAC with count=5: every output is 0 on the next cycle; start restarts a clean run.
